// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier,
// plus a reference function for approximate products.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ACC = 1'b0;
    localparam logic MODE_APX = 1'b1;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_APPROX_K = 4;

    // Sum of shifted partial products with the low k columns of every term cleared.
    function automatic logic [63:0] approx_ref(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int unsigned k);
        logic [63:0] acc;
        logic [63:0] t;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                t   = {32'b0, a} << i;
                t   = t & ~((64'd1 << k) - 64'd1);
                acc = acc + t;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/mult_pp_term.sv
// One partial product: a_reg shifted by i, optionally with the low APPROX_K
// columns cleared in approximate mode, gated by the current multiplier bit.
module mult_pp_term
    import mult_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int APPROX_K = DEF_APPROX_K,
    parameter int IW       = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   a_reg,
    input  logic [IW-1:0]      i,
    input  logic               b_bit,
    input  logic               mode,
    output logic [2*WIDTH-1:0] term
);

    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] keep_mask;

    assign shifted = {{WIDTH{1'b0}}, a_reg} << i;

    genvar gi;
    generate
        for (gi = 0; gi < 2*WIDTH; gi++) begin : g_mask
            if (gi < APPROX_K) begin : g_trunc
                assign keep_mask[gi] = (mode == MODE_ACC);
            end else begin : g_keep
                assign keep_mask[gi] = 1'b1;
            end
        end
    endgenerate

    assign term = b_bit ? (shifted & keep_mask) : '0;

endmodule

// File: rtl/seq_mult_nxn.sv
// Sequential WIDTH x WIDTH unsigned shift-add multiplier with accurate and
// column-truncated approximate modes, valid/ready on both sides.
module seq_mult_nxn
    import mult_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int APPROX_K = DEF_APPROX_K
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               out_mode,
    output logic               busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               mode_reg;
    logic [IW-1:0]      i_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] term;
    logic [2*WIDTH-1:0] p_reg;
    logic               out_valid_reg;
    logic               out_mode_reg;
    logic               busy_reg;

    mult_pp_term #(
        .WIDTH    (WIDTH),
        .APPROX_K (APPROX_K),
        .IW       (IW)
    ) u_term (
        .a_reg (a_reg),
        .i     (i_reg),
        .b_bit (b_reg[i_reg]),
        .mode  (mode_reg),
        .term  (term)
    );

    assign acc_next = acc_reg + term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            mode_reg      <= MODE_ACC;
            i_reg         <= '0;
            acc_reg       <= '0;
            p_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_mode_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        mode_reg <= mode;
                        acc_reg  <= '0;
                        i_reg    <= '0;
                        // A zero operand makes the product zero; skip the iterations.
                        if (a == '0 || b == '0) begin
                            state_reg     <= DONE;
                            p_reg         <= '0;
                            out_valid_reg <= 1'b1;
                            out_mode_reg  <= mode;
                        end else begin
                            state_reg <= BUSY;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    acc_reg <= acc_next;
                    i_reg   <= i_reg + 1'b1;
                    if (i_reg == IW'(WIDTH - 1)) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        p_reg         <= acc_next;
                        out_valid_reg <= 1'b1;
                        out_mode_reg  <= mode_reg;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = out_valid_reg;
    assign p         = p_reg;
    assign out_mode  = out_mode_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Randomized bench for seq_mult_nxn: three configurations (8/K4, 8/K0, 16/K4)
// checked every cycle against an arithmetic model of the product and timing.
module tb_seq_mult_nxn;
    import mult_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    int          sel;

    logic        iv0, iv1, iv2, or0, or1, or2;
    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic        om0, om1, om2, bz0, bz1, bz2;
    logic [15:0] p0, p1;
    logic [31:0] p2;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);
    assign or0 = out_ready && (sel == 0);
    assign or1 = out_ready && (sel == 1);
    assign or2 = out_ready && (sel == 2);

    seq_mult_nxn #(.WIDTH(8), .APPROX_K(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a[7:0]), .b(b[7:0]),
        .mode(mode), .out_valid(ov0), .out_ready(or0), .p(p0), .out_mode(om0), .busy(bz0));
    seq_mult_nxn #(.WIDTH(8), .APPROX_K(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a[7:0]), .b(b[7:0]),
        .mode(mode), .out_valid(ov1), .out_ready(or1), .p(p1), .out_mode(om1), .busy(bz1));
    seq_mult_nxn #(.WIDTH(16), .APPROX_K(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b),
        .mode(mode), .out_valid(ov2), .out_ready(or2), .p(p2), .out_mode(om2), .busy(bz2));

    int cfg_w [3] = '{8, 8, 16};
    int cfg_k [3] = '{4, 0, 4};

    logic        sel_ir, sel_ov, sel_om, sel_busy;
    logic [31:0] sel_p;

    always_comb begin
        sel_ir   = 1'b0;
        sel_ov   = 1'b0;
        sel_om   = 1'b0;
        sel_busy = 1'b0;
        sel_p    = '0;
        case (sel)
            0: begin sel_ir = ir0; sel_ov = ov0; sel_om = om0; sel_busy = bz0; sel_p = {16'b0, p0}; end
            1: begin sel_ir = ir1; sel_ov = ov1; sel_om = om1; sel_busy = bz1; sel_p = {16'b0, p1}; end
            2: begin sel_ir = ir2; sel_ov = ov2; sel_om = om2; sel_busy = bz2; sel_p = p2; end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (sel=%0d, t=%0t)", name, got, exp, sel, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    endtask

    task automatic timeout(input string what);
        n_checks++;
        n_fails++;
        $display("FAIL %s: timeout waiting for DUT", what);
        finish_test();
    endtask

    // Product as exact arithmetic, minus whatever each used term loses below column k.
    function automatic logic [63:0] model(input logic [63:0] av, input logic [63:0] bv,
                                          input logic md, input int k);
        logic [63:0] r;
        r = av * bv;
        if (md) begin
            for (int i = 0; i < 32; i++)
                if (bv[i]) r = r - ((av << i) % (64'd1 << k));
        end
        return r;
    endfunction

    // Cycle counter and model state
    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_seen <= 1'b1;
    end

    logic        pending = 0, seen = 0, nz = 0, was_rst = 0, exp_mode = 0, busy_seen = 0;
    logic [63:0] exp_p = 0, last_p = 0;
    int          exp_lat = 0, acc_cyc = 0, last_lat = 0;
    logic        last_mode = 0;

    always @(negedge clk) begin
        if (rst_seen) begin
            if (was_rst) begin
                chk("rst_out_valid", sel_ov, 0);
                chk("rst_p", sel_p, 0);
                chk("rst_out_mode", sel_om, 0);
                chk("rst_busy", sel_busy, 0);
            end
            chk("in_ready", sel_ir, !rst && !pending);
            if (pending) begin
                busy_seen = busy_seen | sel_busy;
                if (sel_ov) begin
                    if (!seen) begin
                        seen     = 1'b1;
                        last_lat = cyc - acc_cyc + 1;
                        chk("latency", last_lat, exp_lat);
                    end
                    chk("p", sel_p, exp_p);
                    chk("out_mode", sel_om, exp_mode);
                end else if (seen) begin
                    chk("out_valid_held", sel_ov, 1);
                end
                chk("busy", sel_busy, !sel_ov && nz);
            end else begin
                chk("idle_out_valid", sel_ov, 0);
                chk("idle_busy", sel_busy, 0);
            end
        end
        // Advance the model to what the next rising edge will do.
        if (rst) begin
            pending = 1'b0;
            seen    = 1'b0;
            was_rst = 1'b1;
        end else begin
            was_rst = 1'b0;
            if (pending) begin
                if (sel_ov && out_ready) begin
                    pending   = 1'b0;
                    last_p    = sel_p;
                    last_mode = sel_om;
                end
            end else if (in_valid && rst_seen) begin
                logic [63:0] av, bv;
                av        = (cfg_w[sel] == 8) ? {56'b0, a[7:0]} : {48'b0, a};
                bv        = (cfg_w[sel] == 8) ? {56'b0, b[7:0]} : {48'b0, b};
                pending   = 1'b1;
                seen      = 1'b0;
                busy_seen = 1'b0;
                acc_cyc   = cyc + 1;
                nz        = (av != 0) && (bv != 0);
                exp_p     = model(av, bv, mode, cfg_k[sel]);
                exp_mode  = mode;
                exp_lat   = nz ? cfg_w[sel] + 1 : 1;
            end
        end
    end

    int last_acc_wait = 0;

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic md, input int stall);
        int   t, nv;
        logic hs;
        a = av; b = bv; mode = md; in_valid = 1'b1;
        t = 0;
        while (sel_ir !== 1'b1) begin
            @(posedge clk); #1;
            t++;
            if (t > 100) timeout("accept");
        end
        last_acc_wait = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
        t = 0; nv = 0;
        forever begin
            if (sel_ov === 1'b1) begin
                out_ready = (nv >= stall);
                nv++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            hs = (sel_ov === 1'b1) && out_ready;
            @(posedge clk); #1;
            if (hs) break;
            t++;
            if (t > 200) timeout("result");
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_during_rst", sel_ir, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", sel_ir, 1);
        @(posedge clk); #1;

        run_op(16'd100, 16'd200, 1'b0, 0);
        chk("lit_100x200", last_p, 20000);
        chk("lit_100x200_lat", last_lat, 9);
        chk("lit_100x200_mode", last_mode, 0);
        run_op(16'd255, 16'd255, 1'b1, 0);
        chk("lit_apx_255x255", last_p, 64976);
        chk("lit_apx_255x255_mode", last_mode, 1);
        run_op(16'd12, 16'd15, 1'b1, 0);
        chk("lit_apx_12x15", last_p, 160);
        for (int m = 0; m < 2; m++) begin
            run_op(16'd0, 16'd255, 1'(m), 0);
            chk("lit_zero_p", last_p, 0);
            chk("lit_zero_lat", last_lat, 1);
            chk("lit_zero_busy", busy_seen, 0);
        end
        run_op(16'd128, 16'd128, 1'b0, 5);
        chk("lit_stall_128x128", last_p, 16384);
        chk("accept_after_hs_ready", sel_ir, 1);
        run_op(16'd3, 16'd7, 1'b0, 0);
        chk("accept_after_hs_wait", last_acc_wait, 0);
        chk("lit_3x7", last_p, 21);

        // Abort an operation mid-flight with reset.
        a = 16'd50; b = 16'd5; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", sel_ov, 0);
        chk("abort_p", sel_p, 0);
        chk("abort_in_ready", sel_ir, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_result", sel_ov, 0);
        run_op(16'd255, 16'd1, 1'b0, 0);
        chk("lit_after_abort", last_p, 255);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            for (int n = 0; n < 1000; n++) begin
                logic [15:0] av, bv;
                logic        md;
                int          maxv;
                maxv = (cfg_w[s] == 8) ? 255 : 65535;
                av = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(0, maxv));
                bv = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(0, maxv));
                md = 1'($urandom_range(0, 1));
                if (n < 20)
                    chk("pkg_approx_ref", approx_ref({16'b0, av}, {16'b0, bv}, cfg_k[s]),
                        model({48'b0, av}, {48'b0, bv}, 1'b1, cfg_k[s]));
                run_op(av, bv, md, $urandom_range(0, 2));
            end
        end

        repeat (2) @(posedge clk);
        finish_test();
    end

endmodule
